accumulator_add_sub_nbits: RTL and testbench
============================================

# accumulator_add_sub_nbits

Parametrised accumulator for the board-level arithmetic exercises. It generalises the fixed 8-bit latch-and-add path to WIDTH bits and adds subtract, load and clear modes. Operations are triggered by an edge-detected push strobe, so holding the button executes only once. It reports unsigned carry/borrow and signed overflow, counts executed operations, and drives active-low 7-segment codes for both the operand and the accumulator.

## Interface

Parameters:
- WIDTH, 8, operand/accumulator width; multiple of 4, range 4..32
- DIGITS, WIDTH/4, derived, not overridden; number of hex digits per displayed value

Ports:
- Clk  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-high; priority over all other inputs
- a  input  WIDTH  operand (board switches)
- op  input  2  00 LOAD, 01 ADD, 10 SUB, 11 CLEAR
- go  input  1  level strobe (inverted push key); only a 0→1 transition executes
- q  output  WIDTH  accumulator, registered
- cout  output  1  ADD: carry out; SUB: borrow (1 when a > q unsigned); registered
- ovf  output  1  signed two's-complement overflow of last ADD/SUB; registered
- done  output  1  one-cycle pulse, high the cycle after an operation executes
- op_count  output  8  executed-operation counter, saturating
- hex_a  output  7*DIGITS  segment codes of a
- hex_q  output  7*DIGITS  segment codes of q

## Operation

- Edge detect: go_d <= go every cycle; fire = go & ~go_d. op and a are sampled in the fire cycle.
- On fire, by op:
  - LOAD: q <= a; cout <= 0; ovf <= 0.
  - ADD: {cout, q} <= q + a (WIDTH+1-bit sum); ovf <= (q[MSB]==a[MSB]) & (sum[MSB]!=q[MSB]).
  - SUB: q <= q − a mod 2^WIDTH; cout <= (a > q) unsigned; ovf <= (q[MSB]!=a[MSB]) & (diff[MSB]!=q[MSB]).
  - CLEAR: q, cout, ovf and op_count all <= 0.
- Flags are not sticky; each LOAD/ADD/SUB overwrites both. cout and ovf hold between operations.
- op_count increments on every LOAD/ADD/SUB, holds at 255, and is zeroed by CLEAR or reset.
- done <= fire for all four ops, including CLEAR.
- Hex encoding (combinational): digit i takes value bits [4i+3:4i] and drives hex_x[7i+6:7i]. Bit 7i+6 is segment a, bit 7i is segment g; active-low.
- Codes for values 0..F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.

## Timing

- Reset values: q=0, cout=0, ovf=0, done=0, op_count=0, go_d=1.
  - Because go_d resets to 1, go held high through reset does not fire; go must return low and rise again.
- Latency: go first sampled high at edge N with go_d=0. q, cout, ovf, op_count and done are updated at edge N and visible in cycle N+1. done is high for exactly that one cycle.
- Throughput: at most one operation per two cycles, since go must be low for at least one sampled cycle between fires.
- go held high for any length produces exactly one operation.
- a or op changing while go stays high has no effect.
- Reset asserted in the same cycle as fire: reset wins, no operation, done=0. Reset mid-count clears op_count.
- Wrap-around: ADD and SUB wrap modulo 2^WIDTH. Overflow and wrap are reported only through cout and ovf; q is never saturated.
- hex_a follows a combinationally. hex_q changes the cycle after q updates.

## Test plan

- WIDTH=8: LOAD 0x7F, then ADD 0x01 → q=0x80, cout=0, ovf=1, done single pulse, op_count=2.
- WIDTH=8: from q=0x80, ADD 0xFF → q=0x7F, cout=1, ovf=1. Then LOAD 0x05, SUB 0x07 → q=0xFE, cout=1, ovf=0.
- go held high 10 cycles with op=ADD, a=0x01 from q=0 → q=0x01, exactly one done pulse, op_count=1. Release, re-press → q=0x02.
- go high during and after reset release → no op and q=0. Drop go, raise again with LOAD 0x3A → q=0x3A, hex_q digit0=0001000, digit1=0000110.
- 300 ADD presses → op_count stops at 255. CLEAR → q=0, flags=0, op_count=0, done pulses.
- WIDTH=16: LOAD 0x8000, SUB 0x0001 → q=0x7FFF, cout=0, ovf=1, hex_q digits (LSB first) = 0111000, 0111000, 0111000, 0001111.

Source files
------------

// File: rtl/accumulator_add_sub_nbits.sv
// accumulator_add_sub_nbits: WIDTH-bit accumulator with LOAD/ADD/SUB/CLEAR, carry/borrow and
//   signed overflow flags, a saturating operation counter and active-low 7-segment decode.
// Latency: an operation fires on the first cycle go is sampled high after being low; q, cout,
//   ovf, op_count and done are visible the cycle after. hex_a is combinational from a; hex_q
//   follows the q register.
// Backpressure: none. go must be sampled low for at least one cycle between operations, so at
//   most one operation executes every two cycles.
// Ports:
//   Clk, reset       - clock; synchronous active-high reset with priority over everything
//   a, op, go        - operand, opcode (00 LOAD, 01 ADD, 10 SUB, 11 CLEAR), push strobe level
//   q, cout, ovf     - accumulator, carry/borrow, signed overflow (all registered)
//   done, op_count   - one-cycle completion pulse, saturating 8-bit executed-op counter
//   hex_a, hex_q     - segment codes for a and q, digit i at [7i+6:7i], segment a in bit 7i+6
module accumulator_add_sub_nbits #(
  parameter int WIDTH = 8
) (
  input  logic                       Clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           a,
  input  logic [1:0]                 op,
  input  logic                       go,
  output logic [WIDTH-1:0]           q,
  output logic                       cout,
  output logic                       ovf,
  output logic                       done,
  output logic [7:0]                 op_count,
  output logic [7*(WIDTH/4)-1:0]     hex_a,
  output logic [7*(WIDTH/4)-1:0]     hex_q
);

  localparam int DIGITS = WIDTH / 4;
  localparam int MSB    = WIDTH - 1;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             go_q;
  logic             done_q;

  logic             fire;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [7:0]       cnt_inc;

  // go_q resets high so a strobe held through reset must drop and rise again to fire.
  assign fire = go & ~go_q;

  // Extra top bit carries the unsigned carry (ADD) or borrow (SUB, set exactly when a > q).
  assign sum  = {1'b0, acc_q} + {1'b0, a};
  assign diff = {1'b0, acc_q} - {1'b0, a};

  always_comb begin
    acc_d   = acc_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    if (fire) begin
      case (op)
        OP_LOAD: begin
          acc_d  = a;
          cout_d = 1'b0;
          ovf_d  = 1'b0;
          cnt_d  = cnt_inc;
        end
        OP_ADD: begin
          acc_d  = sum[WIDTH-1:0];
          cout_d = sum[WIDTH];
          // Same-sign operands producing a result of the other sign.
          ovf_d  = (acc_q[MSB] == a[MSB]) && (sum[MSB] != acc_q[MSB]);
          cnt_d  = cnt_inc;
        end
        OP_SUB: begin
          acc_d  = diff[WIDTH-1:0];
          cout_d = diff[WIDTH];
          // Opposite-sign operands where the result sign departs from the minuend.
          ovf_d  = (acc_q[MSB] != a[MSB]) && (diff[MSB] != acc_q[MSB]);
          cnt_d  = cnt_inc;
        end
        default: begin
          acc_d  = '0;
          cout_d = 1'b0;
          ovf_d  = 1'b0;
          cnt_d  = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      acc_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= 8'd0;
      go_q   <= 1'b1;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
      go_q   <= go;
      done_q <= fire;
    end
  end

  assign q        = acc_q;
  assign cout     = cout_q;
  assign ovf      = ovf_q;
  assign op_count = cnt_q;
  assign done     = done_q;

  // Active-low segments packed as {a,b,c,d,e,f,g}.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  for (genvar i = 0; i < DIGITS; i++) begin : g_hex
    assign hex_a[7*i+6 -: 7] = seg7(a[4*i+3 -: 4]);
    assign hex_q[7*i+6 -: 7] = seg7(acc_q[4*i+3 -: 4]);
  end

endmodule

// File: tb/tb_accumulator_add_sub_nbits.sv
// tb_accumulator_add_sub_nbits: directed vectors against an 8-bit and a 16-bit instance.
// Latency: inputs driven and outputs sampled on the falling edge, one cycle per press.
// Backpressure: none; each press is followed by one cycle with go low.
module tb_accumulator_add_sub_nbits;

  localparam logic [1:0] LOAD = 2'b00, ADD = 2'b01, SUB = 2'b10, CLR = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  a8;
  logic [1:0]  op8;
  logic        go8;
  logic [7:0]  q8;
  logic        cout8, ovf8, done8;
  logic [7:0]  cnt8;
  logic [13:0] hexa8, hexq8;
  logic [15:0] a16;
  logic [1:0]  op16;
  logic        go16;
  logic [15:0] q16;
  logic        cout16, ovf16, done16;
  logic [7:0]  cnt16;
  logic [27:0] hexa16, hexq16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  accumulator_add_sub_nbits #(.WIDTH(8)) dut8 (
    .Clk(clk), .reset(reset), .a(a8), .op(op8), .go(go8),
    .q(q8), .cout(cout8), .ovf(ovf8), .done(done8), .op_count(cnt8),
    .hex_a(hexa8), .hex_q(hexq8)
  );

  accumulator_add_sub_nbits #(.WIDTH(16)) dut16 (
    .Clk(clk), .reset(reset), .a(a16), .op(op16), .go(go16),
    .q(q16), .cout(cout16), .ovf(ovf16), .done(done16), .op_count(cnt16),
    .hex_a(hexa16), .hex_q(hexq16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Raise go with op/a for the chosen instance; returns one edge later (op executed).
  task automatic press(input bit w16, input logic [1:0] o, input logic [15:0] v);
    if (w16) begin op16 = o; a16 = v; go16 = 1'b1; end
    else     begin op8 = o; a8 = v[7:0]; go8 = 1'b1; end
    @(negedge clk);
  endtask

  task automatic rel();
    go8  = 1'b0;
    go16 = 1'b0;
    @(negedge clk);
  endtask

  int n;

  initial begin
    reset = 1'b1;
    a8 = '0; op8 = LOAD; go8 = 1'b1;
    a16 = '0; op16 = LOAD; go16 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_q", 32'(q8), 32'h0);
    check("rst_cout", 32'(cout8), 32'h0);
    check("rst_ovf", 32'(ovf8), 32'h0);
    check("rst_done", 32'(done8), 32'h0);
    check("rst_cnt", 32'(cnt8), 32'h0);

    // go high through reset release must not fire
    reset = 1'b0;
    a8 = 8'h3A;
    repeat (3) @(negedge clk);
    check("held_go_q", 32'(q8), 32'h0);
    check("held_go_done", 32'(done8), 32'h0);
    check("held_go_cnt", 32'(cnt8), 32'h0);
    rel();
    press(0, LOAD, 16'h3A);
    check("load3a_q", 32'(q8), 32'h3A);
    check("load3a_done", 32'(done8), 32'h1);
    rel();
    check("load3a_hexq", 32'(hexq8), 32'({7'b0000110, 7'b0001000}));
    check("load3a_hexa", 32'(hexa8), 32'({7'b0000110, 7'b0001000}));

    // clear, then LOAD 7F / ADD 01
    press(0, CLR, 16'h0);
    check("clr_done", 32'(done8), 32'h1);
    check("clr_q", 32'(q8), 32'h0);
    check("clr_cnt", 32'(cnt8), 32'h0);
    rel();
    press(0, LOAD, 16'h7F); rel();
    press(0, ADD, 16'h01);
    check("add_q", 32'(q8), 32'h80);
    check("add_cout", 32'(cout8), 32'h0);
    check("add_ovf", 32'(ovf8), 32'h1);
    check("add_done", 32'(done8), 32'h1);
    check("add_cnt", 32'(cnt8), 32'h2);
    rel();
    check("add_done_pulse", 32'(done8), 32'h0);

    press(0, ADD, 16'hFF);
    check("addff_q", 32'(q8), 32'h7F);
    check("addff_cout", 32'(cout8), 32'h1);
    check("addff_ovf", 32'(ovf8), 32'h1);
    rel();
    press(0, LOAD, 16'h05);
    check("load5_cout", 32'(cout8), 32'h0);
    check("load5_ovf", 32'(ovf8), 32'h0);
    rel();
    press(0, SUB, 16'h07);
    check("sub_q", 32'(q8), 32'hFE);
    check("sub_cout", 32'(cout8), 32'h1);
    check("sub_ovf", 32'(ovf8), 32'h0);
    rel();
    check("flags_hold", 32'({cout8, ovf8}), 32'h2);

    // go held for ten cycles, with a/op changing mid-hold
    press(0, CLR, 16'h0); rel();
    op8 = ADD; a8 = 8'h01; go8 = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done8) n++;
      if (i == 4) begin op8 = LOAD; a8 = 8'h55; end
    end
    check("hold_pulses", 32'(n), 32'h1);
    check("hold_q", 32'(q8), 32'h01);
    check("hold_cnt", 32'(cnt8), 32'h1);
    rel();
    press(0, ADD, 16'h01);
    check("repress_q", 32'(q8), 32'h02);
    rel();

    // reset in the same cycle as a fire
    op8 = LOAD; a8 = 8'h99; go8 = 1'b1; reset = 1'b1;
    @(negedge clk);
    check("rstfire_done", 32'(done8), 32'h0);
    check("rstfire_q", 32'(q8), 32'h0);
    check("rstfire_cnt", 32'(cnt8), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("rstfire_after_q", 32'(q8), 32'h0);
    check("rstfire_after_done", 32'(done8), 32'h0);
    rel();

    // counter saturation
    for (int i = 0; i < 300; i++) begin
      press(0, ADD, 16'h01);
      if (i == 253) check("cnt_254", 32'(cnt8), 32'd254);
      if (i == 254) check("cnt_255", 32'(cnt8), 32'd255);
      rel();
    end
    check("sat_cnt", 32'(cnt8), 32'd255);
    check("sat_q", 32'(q8), 32'h2C);
    press(0, ADD, 16'hFF); rel();
    check("wrap_q", 32'(q8), 32'h2B);
    check("wrap_cout", 32'(cout8), 32'h1);
    press(0, CLR, 16'h0);
    check("clr2_done", 32'(done8), 32'h1);
    check("clr2_q", 32'(q8), 32'h0);
    check("clr2_flags", 32'({cout8, ovf8}), 32'h0);
    check("clr2_cnt", 32'(cnt8), 32'h0);
    rel();

    // 16-bit instance
    press(1, LOAD, 16'h8000); rel();
    press(1, SUB, 16'h0001);
    check("w16_q", 32'(q16), 32'h7FFF);
    check("w16_cout", 32'(cout16), 32'h0);
    check("w16_ovf", 32'(ovf16), 32'h1);
    check("w16_cnt", 32'(cnt16), 32'h2);
    rel();
    check("w16_hexq", 32'(hexq16),
          32'({7'b0001111, 7'b0111000, 7'b0111000, 7'b0111000}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
